// File: rtl/led_glow_pkg.sv
// Shared definitions for the multi-channel LED glow controller: channel mode
// encodings and the per-channel phase offset used to stagger the ramp.
package led_glow_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STEADY  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  // Even spacing of CHANNELS phases over the 2^(PWM_BITS+1)-step ramp.
  function automatic int unsigned phase_offset(input int unsigned channels,
                                               input int unsigned pwm_bits,
                                               input int unsigned idx);
    return idx * ((32'd1 << (pwm_bits + 1)) / channels);
  endfunction

endpackage

// File: rtl/sd_pwm_channel.sv
// First-order sigma-delta modulator for one LED: the carry out of a running
// PWM_BITS-wide sum of duty drives the pin, giving duty highs per 2^PWM_BITS cycles.
module sd_pwm_channel #(
  parameter int unsigned PWM_BITS   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                clr,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led
);

  logic [PWM_BITS:0] acc_q, acc_d;

  always_comb begin
    acc_d = {1'b0, acc_q[PWM_BITS-1:0]} + {1'b0, duty};
    if (clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Driven straight from the register so the pin never glitches.
  assign led = acc_q[PWM_BITS] ^ ACTIVE_LOW;

endmodule

// File: rtl/led_glow_multi.sv
// Multi-channel LED glow/breathe controller: a shared prescaled triangle ramp,
// phase-staggered per channel, feeds a per-channel duty mux and sigma-delta modulator.
module led_glow_multi
  import led_glow_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned RAMP_DIV   = 19,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         restart,
  input  logic [2*CHANNELS-1:0]        mode,
  input  logic [PWM_BITS*CHANNELS-1:0] level,
  output logic [CHANNELS-1:0]          LED,
  output logic                         tick
);

  localparam int unsigned PhW = PWM_BITS + 1;

  logic [RAMP_DIV-1:0] pre_q, pre_d;
  logic [PhW-1:0]      ph_q, ph_d;
  logic                tick_q, tick_d;
  logic                step;

  assign step = &pre_q;

  // restart wins over a coincident step.
  always_comb begin
    pre_d  = pre_q + RAMP_DIV'(1);
    ph_d   = step ? ph_q + PhW'(1) : ph_q;
    tick_d = step;
    if (restart) begin
      pre_d  = '0;
      ph_d   = '0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pre_q  <= '0;
      ph_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      ph_q   <= ph_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [PhW-1:0] Offset = PhW'(phase_offset(CHANNELS, PWM_BITS, i));

    logic [PhW-1:0]        p;
    logic [PWM_BITS-1:0]   tri_v;
    logic [PWM_BITS-1:0]   lvl;
    logic [PWM_BITS-1:0]   duty;
    logic [2*PWM_BITS-1:0] prod;
    logic [1:0]            m;

    assign m     = mode[2*i +: 2];
    assign lvl   = level[PWM_BITS*i +: PWM_BITS];
    assign p     = ph_q + Offset;
    assign tri_v = p[PWM_BITS] ? p[PWM_BITS-1:0] : ~p[PWM_BITS-1:0];
    assign prod  = {{PWM_BITS{1'b0}}, tri_v} * {{PWM_BITS{1'b0}}, lvl};

    always_comb begin
      duty = '0;
      case (mode_e'(m))
        MODE_OFF:     duty = '0;
        MODE_STEADY:  duty = lvl;
        // Full-scale level bypasses the truncating scale so the peak reaches tri exactly.
        MODE_BREATHE: duty = (&lvl) ? tri_v : PWM_BITS'(prod >> PWM_BITS);
        MODE_BLINK:   duty = p[PWM_BITS] ? lvl : '0;
      endcase
    end

    sd_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .CLK   (CLK),
      .RESETN(RESETN),
      .clr   (restart),
      .duty  (duty),
      .led   (LED[i])
    );
  end

endmodule

// File: tb/tb_led_glow_multi.sv
// Directed bench for led_glow_multi: table of per-mode high-count windows plus
// hand sequences for tick timing, restart priority, async reset and active-low drive.
module tb_led_glow_multi;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        restart;
  logic [7:0]  mode, mode_al;
  logic [15:0] level, level_al;
  logic [3:0]  LED, led_al;
  logic        tick, tick_al;

  always #5 CLK = ~CLK;

  led_glow_multi #(
    .CHANNELS(4), .PWM_BITS(4), .RAMP_DIV(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .restart(restart), .mode(mode), .level(level),
    .LED(LED), .tick(tick)
  );

  led_glow_multi #(
    .CHANNELS(4), .PWM_BITS(4), .RAMP_DIV(2), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .CLK(CLK), .RESETN(RESETN), .restart(1'b0), .mode(mode_al), .level(level_al),
    .LED(led_al), .tick(tick_al)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic clk_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    clk_cyc();
    restart = 1'b0;
  endtask

  typedef struct {
    string          name;
    logic [7:0]     mode;
    logic [15:0]    level;
    int             skip;
    int             cycles;
    logic [3:0][7:0] expv;
  } vec_t;

  vec_t vecs[7];
  int   cnt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int errs, first_tick, ntick, found;

    // Expected counts: LED highs in a window = floor(cumulative duty / 16) difference.
    vecs[0] = '{"steady 0/8/15/1", 8'h55, 16'h1F80, 0, 160, {8'd10, 8'd150, 8'd80, 8'd0}};
    vecs[1] = '{"steady 4/12/2/7", 8'h55, 16'h72C4, 0, 160, {8'd70, 8'd20, 8'd120, 8'd40}};
    vecs[2] = '{"off",             8'h00, 16'hFFFF, 0, 64,  {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[3] = '{"breathe 15",      8'hAA, 16'hFFFF, 0, 64,  {8'd46, 8'd30, 8'd14, 8'd30}};
    vecs[4] = '{"breathe 8",       8'hAA, 16'h8888, 0, 64,  {8'd22, 8'd14, 8'd6, 8'd14}};
    vecs[5] = '{"blink ph0-15",    8'hFF, 16'h8888, 0, 64,  {8'd16, 8'd32, 8'd16, 8'd0}};
    vecs[6] = '{"blink ph16-31",   8'hFF, 16'h8888, 64, 64, {8'd16, 8'd0, 8'd16, 8'd32}};

    RESETN   = 1'b0;
    restart  = 1'b0;
    mode     = 8'h55;
    level    = 16'hFFFF;
    mode_al  = 8'h05;     // ch0 steady 0, ch1 steady 15, ch2/ch3 off
    level_al = 16'h00F0;

    #12;
    check("reset LED", int'(LED), 0);
    check("reset tick", int'(tick), 0);
    check("reset LED active-low", int'(led_al), 15);
    check("reset tick active-low", int'(tick_al), 0);
    @(negedge CLK);
    RESETN = 1'b1;

    for (int v = 0; v < 7; v++) begin
      mode  = vecs[v].mode;
      level = vecs[v].level;
      do_restart();
      repeat (vecs[v].skip) clk_cyc();
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      repeat (vecs[v].cycles) begin
        clk_cyc();
        for (int c = 0; c < 4; c++) cnt[c] += int'(LED[c]);
      end
      for (int c = 0; c < 4; c++)
        check($sformatf("%s ch%0d", vecs[v].name, c), cnt[c], int'(vecs[v].expv[c]));
    end

    // Level 8 alternates strictly; ticks every 4 cycles starting 4 after restart.
    mode  = 8'h55;
    level = 16'h1F80;
    do_restart();
    errs = 0;
    first_tick = 0;
    ntick = 0;
    for (int c = 1; c <= 32; c++) begin
      clk_cyc();
      if (LED[1] != ((c % 2) == 0)) errs++;
      if (tick) begin
        ntick++;
        if (first_tick == 0) first_tick = c;
      end
    end
    check("level 8 alternation errors", errs, 0);
    check("first tick after restart", first_tick, 4);
    check("ticks in 32 cycles", ntick, 8);

    // Restart at ph=13 on the same cycle as a step.
    mode  = 8'hAA;
    level = 16'hFFFF;
    do_restart();
    repeat (55) clk_cyc();
    check("ph before restart", int'(dut.ph_q), 13);
    check("pre before restart", int'(dut.pre_q), 3);
    restart = 1'b1;
    clk_cyc();
    restart = 1'b0;
    check("ph after restart", int'(dut.ph_q), 0);
    check("pre after restart", int'(dut.pre_q), 0);
    check("tick after restart", int'(tick), 0);
    check("LED after restart", int'(LED), 0);
    cnt[0] = 0;
    repeat (64) begin
      clk_cyc();
      cnt[0] += int'(LED[0]);
    end
    check("breathe ch0 after restart", cnt[0], 30);

    // Async reset between edges while tick is high.
    mode  = 8'h55;
    level = 16'hFFFF;
    do_restart();
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      clk_cyc();
      if (tick) found = 1;
    end
    check("tick seen before reset", found, 1);
    #2;
    RESETN = 1'b0;
    #1;
    check("async reset LED", int'(LED), 0);
    check("async reset tick", int'(tick), 0);
    check("async reset LED active-low", int'(led_al), 15);
    @(negedge CLK);
    RESETN = 1'b1;
    errs = 0;
    for (int k = 1; k <= 3; k++) begin
      clk_cyc();
      if (tick) errs++;
    end
    check("early ticks after reset", errs, 0);
    clk_cyc();
    check("tick 4 cycles after reset", int'(tick), 1);

    // Active-low instance: steady 0 stays high; steady 15 then off goes inactive.
    cnt[0] = 0;
    cnt[1] = 0;
    cnt[2] = 0;
    repeat (16) begin
      clk_cyc();
      cnt[0] += int'(led_al[0]);
      cnt[1] += int'(!led_al[1]);
      cnt[2] += int'(led_al[3:2] == 2'b11);
    end
    check("active-low steady 0 high count", cnt[0], 16);
    check("active-low steady 15 low count", cnt[1], 15);
    check("active-low off channels high", cnt[2], 16);
    mode_al = 8'h01;
    clk_cyc();
    clk_cyc();
    check("active-low off within 2 cycles", int'(led_al[1]), 1);
    cnt[1] = 0;
    repeat (16) begin
      clk_cyc();
      cnt[1] += int'(!led_al[1]);
    end
    check("active-low off stays inactive", cnt[1], 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/led_glow_multi.md
Name: led_glow_multi

Overview:
- Multi-channel LED glow/breathe controller for the 16 MHz board clock.
- Each channel drives one LED through a first-order sigma-delta modulator. The modulator input is one of four modes: off, steady, breathe or blink.
- Breathe and blink channels share one triangle ramp. Channels are phase-staggered evenly so LEDs glow in a rolling pattern.
- Sits at top level between user/status logic (mode and level inputs) and the LED pins.

Parameters:
- CHANNELS, 4, number of LED channels; power of two, 1..2^(PWM_BITS+1).
- PWM_BITS, 4, brightness resolution N; duty = value/2^N.
- RAMP_DIV, 19, prescaler width; ramp advances once every 2^RAMP_DIV clocks.
- ACTIVE_LOW, 0, 1 inverts all LED outputs (inactive level = 1).

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous active-low reset.
- restart  in  1  synchronous pulse; realigns the ramp and clears the modulators.
- mode  in  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 steady, 10 breathe, 11 blink.
- level  in  PWM_BITS*CHANNELS  per-channel brightness, channel i at [N*i+N-1:N*i].
- LED  out  CHANNELS  LED drive, bit i = channel i.
- tick  out  1  one-cycle pulse when the ramp phase advances.

Behaviour:
- Reset (RESETN low, async): prescaler, phase and all accumulators = 0; tick = 0; LED = inactive level (0, or all ones if ACTIVE_LOW).
- Prescaler pre, RAMP_DIV bits, increments every cycle and wraps.
- Internal step = (pre == all ones). tick is the registered step, so it is high the cycle phase changes.
- Phase ph, N+1 bits, increments on step and wraps 2^(N+1)-1 -> 0.
- Channel phase: p_i = (ph + i*2^(N+1)/CHANNELS) mod 2^(N+1).
- Triangle: tri_i = p_i[N] ? p_i[N-1:0] : ~p_i[N-1:0].
  - Runs 15..0 over ph 0..15, then 0..15 over ph 16..31 (N=4).
- Duty select per mode:
  - off: 0.
  - steady: level_i.
  - breathe: (tri_i * level_i) >> N, full-width product truncated; level all ones -> tri_i exactly.
  - blink: p_i[N] ? level_i : 0.
- Modulator: acc_i is N+1 bits; acc_i <= acc_i[N-1:0] + duty_i each cycle. LED_i = acc_i[N] XOR ACTIVE_LOW, taken from the register.
  - Exactly duty highs per 2^N cycles in steady state.
  - duty 0 -> never high.
  - Maximum duty is (2^N-1)/2^N.
- Latency: a mode/level change affects the acc update on the next edge; LED reflects it one cycle later.
- Mode and level are sampled every cycle with no handshake. The caller holds them stable; mid-period changes are legal and cause no glitch beyond normal sigma-delta transition.
- restart high: pre, ph and every acc_i <= 0; tick <= 0; LED inactive next cycle. restart takes priority over the step on the same cycle.
- Reset mid-operation: immediate async clear, identical to the power-on state.
- CHANNELS = 1: offset 0; behaviour reduces to a single-LED glow.

Decomposition:
- Package led_glow_pkg holds:
  - mode encodings MODE_OFF=2'b00, MODE_STEADY=2'b01, MODE_BREATHE=2'b10, MODE_BLINK=2'b11;
  - the helper constant for phase offset per channel.
- Sub-module sd_pwm_channel (params PWM_BITS, ACTIVE_LOW):
  - ports CLK, RESETN, clr, duty -> led;
  - implements acc and output; instantiated CHANNELS times via generate.
- Ramp, prescaler and duty mux stay in the top.

Test Plan (CHANNELS=4, PWM_BITS=4, RAMP_DIV=2, ACTIVE_LOW=0 unless stated):
- Reset, all channels steady, levels 0/8/15/1, run 160 cycles -> LED0 high 0 cycles, LED1 high 80 (strict alternation), LED2 high 150, LED3 high 10.
- All channels breathe, level 15 -> tick every 4 cycles; tri_0 at ph=0 is 15; tri_1 (offset 8) at ph=0 is 7; tri_2 is 0 at ph=0. Per-16-cycle window counts match tri.
- Blink, level 8 -> channel 0 outputs 0 for ph 0..15 and 50% for ph 16..31. Channel 2 is the inverse pattern (offset 16).
- restart pulsed at ph=13 -> next cycle ph=0, pre=0, all LED=0, tick=0; breathe sequence restarts from tri=15.
- RESETN asserted mid-cycle (async, between edges) -> LED=0 and tick=0 immediately. After release, first tick occurs 4 cycles later.
- ACTIVE_LOW=1, steady level 0 -> LED constantly 1. Mode change steady 15 -> off -> LED inactive within 2 cycles.
